// File: rtl/stack_bus_upstream_pkg.sv
// Shared definitions for the stack-bus upstream lane arbiter:
// beat control encoding, FSM states and the SOP/EOP decode helper.
package stack_bus_upstream_pkg;

    localparam logic [1:0] CNTL_MOP     = 2'b00;
    localparam logic [1:0] CNTL_SOP     = 2'b01;
    localparam logic [1:0] CNTL_EOP     = 2'b10;
    localparam logic [1:0] CNTL_SOP_EOP = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    typedef struct packed {
        logic sop;
        logic eop;
    } cntl_dec_t;

    function automatic cntl_dec_t decode_cntl(input logic [1:0] cntl);
        cntl_dec_t d;
        d.sop = (cntl == CNTL_SOP) || (cntl == CNTL_SOP_EOP);
        d.eop = !((cntl == CNTL_MOP) || (cntl == CNTL_SOP));
        return d;
    endfunction

endpackage

// File: rtl/rr_arbiter_pkt.sv
// Combinational round-robin pick: first eligible requester at or above
// i_rr_ptr, wrapping to index 0.
module rr_arbiter_pkt #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_elig,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any
);

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_any && i_elig[wrap_idx(i_rr_ptr, k)]) begin
                o_any                             = 1'b1;
                o_grant_oh[wrap_idx(i_rr_ptr, k)] = 1'b1;
                o_grant_idx                       = wrap_idx(i_rr_ptr, k);
            end
        end
    end

endmodule

// File: rtl/stack_bus_upstream_arbiter.sv
// Shares one stack-bus upstream lane among NUM_REQ PEs. Grant is locked
// SOP..EOP so packets never interleave; output stage is a registered valid/ready slot.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; arbitrate SOP beats, drain stray non-SOP beats
// XFER  | grant_id owns the lane until its EOP/SOP_EOP beat is accepted
module stack_bus_upstream_arbiter
    import stack_bus_upstream_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset_poweron,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [2*NUM_REQ-1:0]      req_cntl,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      up_valid,
    output logic [1:0]                up_cntl,
    output logic [DATA_W-1:0]         up_data,
    input  logic                      up_ready,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      protocol_err,
    input  logic                      err_clr
);

    state_t              r_state, w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr, r_grant_id;
    logic [NUM_REQ-1:0]  r_grant_oh;
    logic                r_first, r_up_valid, r_err;
    logic [1:0]          r_up_cntl;
    logic [DATA_W-1:0]   r_up_data;

    cntl_dec_t [NUM_REQ-1:0] w_dec;
    logic [NUM_REQ-1:0]  w_elig, w_stray, w_drain_oh, w_win_oh;
    logic [ID_W-1:0]     w_win_idx;
    logic                w_any_elig;
    logic                w_own_valid;
    logic [1:0]          w_own_cntl;
    logic [DATA_W-1:0]   w_own_data;
    cntl_dec_t           w_own_dec;
    logic                w_slot_free, w_accept, w_pkt_end, w_drain, w_err_set;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
        assign w_dec[gi]   = decode_cntl(req_cntl[2*gi +: 2]);
        assign w_elig[gi]  = req_valid[gi] && w_dec[gi].sop;
        assign w_stray[gi] = req_valid[gi] && !w_dec[gi].sop;
    end

    rr_arbiter_pkt #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .i_elig      (w_elig),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant_oh  (w_win_oh),
        .o_grant_idx (w_win_idx),
        .o_any       (w_any_elig)
    );

    always_comb begin
        w_own_valid = 1'b0;
        w_own_cntl  = '0;
        w_own_data  = '0;
        w_own_dec   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_oh[i]) begin
                w_own_valid = req_valid[i];
                w_own_cntl  = req_cntl[2*i +: 2];
                w_own_data  = req_data[DATA_W*i +: DATA_W];
                w_own_dec   = w_dec[i];
            end
        end
    end

    // A held upstream beat blocks the next accept, which also protects a
    // trailing EOP still waiting in the slot after the FSM has returned to IDLE.
    assign w_slot_free = !r_up_valid || up_ready;
    assign w_accept    = (r_state == ST_XFER) && w_own_valid && w_slot_free;
    assign w_pkt_end   = w_accept && w_own_dec.eop;
    assign w_drain_oh  = w_stray & (~w_stray + NUM_REQ'(1));
    assign w_drain     = (r_state == ST_IDLE) && !w_any_elig && (|w_stray);
    assign w_err_set   = w_drain || (w_accept && !r_first && w_own_dec.sop);

    always_comb begin
        req_ready = '0;
        if (r_state == ST_XFER)
            req_ready = r_grant_oh & {NUM_REQ{w_slot_free}};
        else if (w_drain && reset_poweron)
            req_ready = w_drain_oh;
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) r_state <= ST_IDLE;
        else                r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_elig) w_state_nxt = ST_XFER;
            ST_XFER: if (w_pkt_end)  w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_grant_oh <= '0;
            r_first    <= 1'b0;
            r_up_valid <= 1'b0;
            r_up_cntl  <= '0;
            r_up_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_any_elig) begin
                r_grant_id <= w_win_idx;
                r_grant_oh <= w_win_oh;
                r_first    <= 1'b1;
            end else if (w_accept) begin
                r_first    <= 1'b0;
            end
            if (w_pkt_end)
                r_rr_ptr <= (r_grant_id == ID_W'(NUM_REQ-1)) ? '0 : r_grant_id + ID_W'(1);
            if (w_accept) begin
                r_up_valid <= 1'b1;
                r_up_cntl  <= w_own_cntl;
                r_up_data  <= w_own_data;
            end else if (up_ready) begin
                r_up_valid <= 1'b0;
            end
            if (w_err_set)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign up_valid     = r_up_valid;
    assign up_cntl      = r_up_cntl;
    assign up_data      = r_up_data;
    assign grant_id     = r_grant_id;
    assign busy         = (r_state == ST_XFER);
    assign protocol_err = r_err;

endmodule

// File: tb/tb_stack_bus_upstream_arbiter.sv
// Bench for stack_bus_upstream_arbiter: packet-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_stack_bus_upstream_arbiter;
    localparam int NR = 4;
    localparam int DW = 64;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             reset_poweron = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [2*NR-1:0]  req_cntl = '0;
    logic [DW*NR-1:0] req_data = '0;
    logic [NR-1:0]    req_ready;
    logic             up_valid;
    logic [1:0]       up_cntl;
    logic [DW-1:0]    up_data;
    logic             up_ready = 1'b1;
    logic [IW-1:0]    grant_id;
    logic             busy;
    logic             protocol_err;
    logic             err_clr = 1'b0;

    always #5 clk = ~clk;

    stack_bus_upstream_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .reset_poweron(reset_poweron),
        .req_valid(req_valid), .req_cntl(req_cntl), .req_data(req_data), .req_ready(req_ready),
        .up_valid(up_valid), .up_cntl(up_cntl), .up_data(up_data), .up_ready(up_ready),
        .grant_id(grant_id), .busy(busy), .protocol_err(protocol_err), .err_clr(err_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [DW+1:0] act, input logic [DW+1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    int             m_owner = -1;
    int             m_ptr = 0;
    bit             m_first = 0;
    bit             m_uv = 0;
    bit             m_err = 0;
    logic [1:0]     m_uc = '0;
    logic [DW-1:0]  m_ud = '0;
    logic [DW+1:0]  m_log[$];
    int             m_grants[$];
    logic [NR-1:0]  m_rdy;
    logic [1:0]     m_c;
    bit             m_set, m_fire, m_found;
    int             m_j;

    function automatic logic [1:0] cntl_of(input int i);
        return req_cntl[2*i +: 2];
    endfunction

    function automatic bit sop_of(input int i);
        logic [1:0] c;
        c = cntl_of(i);
        return c[0];
    endfunction

    function automatic bit any_sop();
        bit a = 0;
        for (int i = 0; i < NR; i++) if (req_valid[i] && sop_of(i)) a = 1;
        return a;
    endfunction

    function automatic logic [NR-1:0] exp_ready();
        logic [NR-1:0] r = '0;
        bit done = 0;
        if (!reset_poweron) return '0;
        if (m_owner >= 0) r[m_owner] = !m_uv || up_ready;
        else if (!any_sop()) begin
            for (int i = 0; i < NR; i++)
                if (!done && req_valid[i]) begin r[i] = 1'b1; done = 1; end
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            m_owner = -1; m_ptr = 0; m_first = 0; m_uv = 0;
            m_uc = '0; m_ud = '0; m_err = 0;
        end else begin
            m_rdy  = exp_ready();
            m_set  = 0;
            m_fire = m_uv && up_ready;
            if (m_fire) m_log.push_back({m_uc, m_ud});
            if (m_owner >= 0) begin
                if (req_valid[m_owner] && m_rdy[m_owner]) begin
                    m_c = cntl_of(m_owner);
                    if (!m_first && m_c[0]) m_set = 1;
                    m_uv = 1; m_uc = m_c; m_ud = req_data[DW*m_owner +: DW]; m_first = 0;
                    if (m_c[1]) begin m_ptr = (m_owner + 1) % NR; m_owner = -1; end
                end else if (m_fire) m_uv = 0;
            end else begin
                if (m_fire) m_uv = 0;
                if (any_sop()) begin
                    m_found = 0;
                    for (int k = 0; k < NR; k++) begin
                        m_j = (m_ptr + k) % NR;
                        if (!m_found && req_valid[m_j] && sop_of(m_j)) begin
                            m_found = 1; m_owner = m_j;
                        end
                    end
                    m_first = 1;
                    m_grants.push_back(m_owner);
                end else if (m_rdy != '0) m_set = 1;
            end
            if (m_set) m_err = 1;
            else if (err_clr) m_err = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    int cur_run = 0, last_run = 0, dut_xfers = 0, cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        check("req_ready", req_ready, exp_ready());
        check("up_valid", up_valid, m_uv);
        check("up_cntl", up_cntl, m_uc);
        check("up_data", up_data, m_ud);
        check("busy", busy, m_owner >= 0);
        check("protocol_err", protocol_err, m_err);
        if (m_owner >= 0) check("grant_id", grant_id, m_owner);
        if (up_valid) cur_run++;
        else if (cur_run != 0) begin last_run = cur_run; cur_run = 0; end
        if (up_valid && up_ready) dut_xfers++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input int i, input logic [1:0] c, input logic [DW-1:0] d);
        bit acc = 0;
        int t = 0;
        req_valid[i] = 1'b1;
        req_cntl[2*i +: 2] = c;
        req_data[DW*i +: DW] = d;
        while (!acc && t < 100) begin
            @(negedge clk); acc = req_ready[i];
            @(posedge clk); t++;
        end
        #1;
        if (!acc) begin
            n_checks++;
            $display("FAIL send_beat_timeout: req %0d beat %0h not accepted in %0d cycles", i, d, t);
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic send_pkt(input int i, input int n, input logic [DW-1:0] base);
        logic [1:0] c;
        for (int k = 0; k < n; k++) begin
            if (n == 1)          c = 2'b11;
            else if (k == 0)     c = 2'b01;
            else if (k == n - 1) c = 2'b10;
            else                 c = 2'b00;
            send_beat(i, c, base + DW'(k));
        end
    endtask

    task automatic expect_log(input string name, input int idx, input logic [1:0] c, input logic [DW-1:0] d);
        if (idx < m_log.size()) check(name, m_log[idx], {c, d});
        else begin
            n_checks++;
            $display("FAIL %s: got no entry %0d expected %0h", name, idx, {c, d});
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_up_valid"}, up_valid, 0);
        check({tag, "_up_cntl"}, up_cntl, 0);
        check({tag, "_up_data"}, up_data, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_protocol_err"}, protocol_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    int t0;

    initial begin
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        #2 reset_poweron = 1'b1;
        sync();

        // single requester, 4-beat packet
        m_log.delete();
        fork
            send_pkt(0, 4, 64'hA0);
            begin
                @(posedge clk); #2;
                check("t1_busy_after_sop", busy, 1);
                check("t1_grant_after_sop", grant_id, 0);
            end
        join
        check("t1_busy_after_eop", busy, 0);
        repeat (3) sync();
        check("t1_up_valid_run", last_run, 4);
        check("t1_log_size", m_log.size(), 4);
        expect_log("t1_beat0", 0, 2'b01, 64'hA0);
        expect_log("t1_beat1", 1, 2'b00, 64'hA1);
        expect_log("t1_beat2", 2, 2'b00, 64'hA2);
        expect_log("t1_beat3", 3, 2'b10, 64'hA3);

        // four simultaneous single-beat packets, pointer starting at 0
        @(negedge clk); #2 reset_poweron = 1'b0;
        #1 check_reset_vals("t2_rst");
        @(negedge clk); #2 reset_poweron = 1'b1;
        sync();
        m_log.delete(); m_grants.delete();
        t0 = cyc;
        fork
            send_pkt(0, 1, 64'hC0);
            send_pkt(1, 1, 64'hC1);
            send_pkt(2, 1, 64'hC2);
            send_pkt(3, 1, 64'hC3);
        join
        check("t2_cycles", cyc - t0, 8);
        repeat (2) sync();
        check("t2_grants", m_grants.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < m_grants.size()) check($sformatf("t2_grant%0d", k), m_grants[k], k);
        check("t2_rr_ptr", m_ptr, 0);
        expect_log("t2_beat3", 3, 2'b11, 64'hC3);

        // backpressure on a 3-beat packet
        m_log.delete();
        dut_xfers = 0;
        fork
            send_pkt(2, 3, 64'hB0);
            begin
                int t = 0;
                while (!up_valid && t < 50) begin @(negedge clk); t++; end
                check("t3_saw_up_valid", up_valid, 1);
                @(posedge clk); #1 up_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("t3_hold_data", up_data, 64'hB1);
                    check("t3_hold_ready", req_ready[2], 0);
                    @(posedge clk); #1;
                end
                up_ready = 1'b1;
            end
        join
        repeat (3) sync();
        check("t3_xfers", dut_xfers, 3);
        check("t3_log_size", m_log.size(), 3);
        expect_log("t3_beat0", 0, 2'b01, 64'hB0);
        expect_log("t3_beat1", 1, 2'b00, 64'hB1);
        expect_log("t3_beat2", 2, 2'b10, 64'hB2);

        // framing errors: drain in IDLE, err_clr, set-wins, mid-packet SOP
        req_valid[1] = 1'b1; req_cntl[3:2] = 2'b00; req_data[127:64] = 64'hD0;
        @(negedge clk);
        check("t4_drain_ready", req_ready, 4'b0010);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        check("t4_err_set", protocol_err, 1);
        err_clr = 1'b1;
        sync(); err_clr = 1'b0;
        check("t4_err_clr", protocol_err, 0);
        req_valid[1] = 1'b1; req_cntl[3:2] = 2'b00;
        req_valid[3] = 1'b1; req_cntl[7:6] = 2'b10;
        err_clr = 1'b1;
        @(negedge clk);
        check("t4_drain_lowest", req_ready, 4'b0010);
        @(posedge clk); #1 req_valid = '0; err_clr = 1'b0;
        check("t4_set_wins", protocol_err, 1);
        err_clr = 1'b1;
        sync(); err_clr = 1'b0;
        m_log.delete();
        send_beat(2, 2'b01, 64'hE0);
        send_beat(2, 2'b01, 64'hE1);
        check("t4_mid_sop_err", protocol_err, 1);
        check("t4_mid_sop_busy", busy, 1);
        send_beat(2, 2'b10, 64'hE2);
        repeat (3) sync();
        expect_log("t4_beat0", 0, 2'b01, 64'hE0);
        expect_log("t4_beat1", 1, 2'b01, 64'hE1);
        expect_log("t4_beat2", 2, 2'b10, 64'hE2);
        send_beat(3, 2'b01, 64'hF0);
        send_beat(3, 2'b11, 64'hF1);
        check("t4_sop_eop_ends", busy, 0);

        // reset during beat 2 of 4
        sync();
        send_beat(3, 2'b01, 64'h50);
        send_beat(3, 2'b00, 64'h51);
        req_valid[3] = 1'b1; req_cntl[7:6] = 2'b00; req_data[255:192] = 64'h52;
        @(negedge clk); #2 reset_poweron = 1'b0;
        req_valid = '0;
        #1 check_reset_vals("t5_rst");
        repeat (2) @(negedge clk);
        #2 reset_poweron = 1'b1;
        m_log.delete();
        check("t5_rr_ptr", m_ptr, 0);
        check("t5_busy", busy, 0);
        sync();
        send_pkt(3, 4, 64'h60);
        repeat (3) sync();
        check("t5_log_size", m_log.size(), 4);
        expect_log("t5_beat0", 0, 2'b01, 64'h60);
        expect_log("t5_beat3", 3, 2'b10, 64'h63);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
